// File: rtl/xif_issue_buffer.sv
// In-order issue buffer for an X-interface coprocessor: accepted offloads wait for commit/kill, then dispatch from the head.
// Optional XIF_IBUF_PASSTHRU_EN adds an empty-buffer, same-cycle issue+commit bypass to the dispatch port.
module xif_issue_buffer #(
    parameter int DEPTH       = 4,
    parameter int X_ID_WIDTH  = 4,
    parameter int X_NUM_RS    = 3,
    parameter int X_RFR_WIDTH = 32
) (
    input  logic                            clk_i,
    input  logic                            rst_i,
    input  logic                            issue_valid_i,
    output logic                            issue_ready_o,
    input  logic [31:0]                     issue_instr_i,
    input  logic [X_ID_WIDTH-1:0]           issue_id_i,
    input  logic [X_NUM_RS*X_RFR_WIDTH-1:0] issue_rs_i,
    input  logic [X_NUM_RS-1:0]             issue_rs_valid_i,
    input  logic                            accept_i,
    input  logic                            commit_valid_i,
    input  logic [X_ID_WIDTH-1:0]           commit_id_i,
    input  logic                            commit_kill_i,
    output logic                            disp_valid_o,
    input  logic                            disp_ready_i,
    output logic [31:0]                     disp_instr_o,
    output logic [X_ID_WIDTH-1:0]           disp_id_o,
    output logic [X_NUM_RS*X_RFR_WIDTH-1:0] disp_rs_o,
    output logic [$clog2(DEPTH):0]          count_o,
    output logic                            full_o,
    output logic                            empty_o
);
    localparam int PW  = $clog2(DEPTH);
    localparam int CW  = PW + 1;
    localparam int RSW = X_NUM_RS * X_RFR_WIDTH;
    localparam logic [PW-1:0] PTR_ONE = 1;
    localparam logic [CW-1:0] CNT_ONE = 1;

    typedef enum logic [1:0] {FREE, WAIT_COMMIT, COMMITTED, KILLED} entry_state_t;

    entry_state_t          state_reg [DEPTH];
    logic [31:0]           instr_reg [DEPTH];
    logic [X_ID_WIDTH-1:0] id_reg    [DEPTH];
    logic [RSW-1:0]        rs_reg    [DEPTH];
    logic [PW-1:0]         head_reg;
    logic [PW-1:0]         tail_reg;
    logic [CW-1:0]         count_reg;

    logic [DEPTH-1:0] commit_hit;
    logic             alloc;
    logic             new_hit;
    logic             head_committed;
    logic             head_killed;
    logic             pop;
    logic             store;
    entry_state_t     commit_state;
    entry_state_t     alloc_state;

    assign count_o       = count_reg;
    assign full_o        = (count_reg == CW'(DEPTH));
    assign empty_o       = (count_reg == '0);
    assign issue_ready_o = !full_o && (!accept_i || (&issue_rs_valid_i));
    assign alloc         = issue_valid_i && issue_ready_o && accept_i;
    assign new_hit       = commit_valid_i && (commit_id_i == issue_id_i);
    assign commit_state  = commit_kill_i ? KILLED : COMMITTED;
    assign alloc_state   = new_hit ? commit_state : WAIT_COMMIT;

    genvar gi;
    generate
        for (gi = 0; gi < DEPTH; gi++) begin : g_hit
            assign commit_hit[gi] = commit_valid_i && (state_reg[gi] == WAIT_COMMIT)
                                    && (id_reg[gi] == commit_id_i);
        end
    endgenerate

    assign head_committed = (state_reg[head_reg] == COMMITTED);
    assign head_killed    = (state_reg[head_reg] == KILLED);
    // A killed head leaves silently; a committed head leaves on the dispatch handshake.
    assign pop            = (head_committed && disp_ready_i) || head_killed;

`ifdef XIF_IBUF_PASSTHRU_EN
    logic passthru;
    assign passthru     = empty_o && alloc && new_hit && !commit_kill_i;
    assign disp_valid_o = head_committed || passthru;
    assign disp_instr_o = passthru ? issue_instr_i : instr_reg[head_reg];
    assign disp_id_o    = passthru ? issue_id_i    : id_reg[head_reg];
    assign disp_rs_o    = passthru ? issue_rs_i    : rs_reg[head_reg];
    // A bypassed instruction that is taken immediately never occupies an entry.
    assign store        = alloc && !(passthru && disp_ready_i);
`else
    assign disp_valid_o = head_committed;
    assign disp_instr_o = instr_reg[head_reg];
    assign disp_id_o    = id_reg[head_reg];
    assign disp_rs_o    = rs_reg[head_reg];
    assign store        = alloc;
`endif

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            for (int i = 0; i < DEPTH; i++) begin
                state_reg[i] <= FREE;
            end
            head_reg  <= '0;
            tail_reg  <= '0;
            count_reg <= '0;
        end else begin
            for (int i = 0; i < DEPTH; i++) begin
                if (commit_hit[i]) begin
                    state_reg[i] <= commit_state;
                end
            end
            if (pop) begin
                state_reg[head_reg] <= FREE;
                head_reg            <= head_reg + PTR_ONE;
            end
            if (store) begin
                state_reg[tail_reg] <= alloc_state;
                tail_reg            <= tail_reg + PTR_ONE;
            end
            if (store && !pop) begin
                count_reg <= count_reg + CNT_ONE;
            end else if (pop && !store) begin
                count_reg <= count_reg - CNT_ONE;
            end
        end
    end

    // Payload storage needs no reset; an entry is only read once its state says it is live.
    always_ff @(posedge clk_i) begin
        if (store) begin
            instr_reg[tail_reg] <= issue_instr_i;
            id_reg[tail_reg]    <= issue_id_i;
            rs_reg[tail_reg]    <= issue_rs_i;
        end
    end
endmodule

// File: tb/tb_xif_issue_buffer.sv
// Self-checking bench for xif_issue_buffer: directed scenarios plus randomized traffic against a queue-based model.
module tb_xif_issue_buffer;
    localparam int DEPTH = 4;
    localparam int IDW   = 4;
    localparam int NRS   = 3;
    localparam int RW    = 32;
    localparam int S_WAIT = 1;
    localparam int S_COMM = 2;
    localparam int S_KILL = 3;

    logic              clk_i = 1'b0;
    logic              rst_i;
    logic              issue_valid_i;
    logic              issue_ready_o;
    logic [31:0]       issue_instr_i;
    logic [IDW-1:0]    issue_id_i;
    logic [NRS*RW-1:0] issue_rs_i;
    logic [NRS-1:0]    issue_rs_valid_i;
    logic              accept_i;
    logic              commit_valid_i;
    logic [IDW-1:0]    commit_id_i;
    logic              commit_kill_i;
    logic              disp_valid_o;
    logic              disp_ready_i;
    logic [31:0]       disp_instr_o;
    logic [IDW-1:0]    disp_id_o;
    logic [NRS*RW-1:0] disp_rs_o;
    logic [2:0]        count_o;
    logic              full_o;
    logic              empty_o;

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic [31:0]       instr;
        logic [IDW-1:0]    id;
        logic [NRS*RW-1:0] rs;
        int                st;
    } ent_t;
    ent_t q[$];

    xif_issue_buffer #(.DEPTH(DEPTH), .X_ID_WIDTH(IDW), .X_NUM_RS(NRS), .X_RFR_WIDTH(RW)) dut (
        .clk_i(clk_i), .rst_i(rst_i),
        .issue_valid_i(issue_valid_i), .issue_ready_o(issue_ready_o),
        .issue_instr_i(issue_instr_i), .issue_id_i(issue_id_i),
        .issue_rs_i(issue_rs_i), .issue_rs_valid_i(issue_rs_valid_i),
        .accept_i(accept_i),
        .commit_valid_i(commit_valid_i), .commit_id_i(commit_id_i), .commit_kill_i(commit_kill_i),
        .disp_valid_o(disp_valid_o), .disp_ready_i(disp_ready_i),
        .disp_instr_o(disp_instr_o), .disp_id_o(disp_id_o), .disp_rs_o(disp_rs_o),
        .count_o(count_o), .full_o(full_o), .empty_o(empty_o)
    );

    always #5 clk_i = ~clk_i;

    function automatic bit exp_ready();
        return (q.size() < DEPTH) && (!accept_i || (&issue_rs_valid_i));
    endfunction

    function automatic bit exp_pass();
`ifdef XIF_IBUF_PASSTHRU_EN
        return (q.size() == 0) && issue_valid_i && exp_ready() && accept_i && commit_valid_i
               && !commit_kill_i && (commit_id_i == issue_id_i);
`else
        return 1'b0;
`endif
    endfunction

    function automatic bit exp_disp_valid();
        return exp_pass() || ((q.size() > 0) && (q[0].st == S_COMM));
    endfunction

    function automatic bit id_in_q(logic [IDW-1:0] id);
        foreach (q[i]) if (q[i].id == id) return 1'b1;
        return 1'b0;
    endfunction

    // Model update for the inputs currently driven, then advance one clock.
    task automatic tick();
        bit   alloc, pass, do_pop;
        ent_t e;
        if (rst_i) begin
            q.delete();
        end else begin
            alloc  = issue_valid_i && exp_ready() && accept_i;
            pass   = exp_pass();
            do_pop = (q.size() > 0) && (((q[0].st == S_COMM) && disp_ready_i) || (q[0].st == S_KILL));
            if (commit_valid_i) begin
                foreach (q[i]) begin
                    if (q[i].st == S_WAIT && q[i].id == commit_id_i)
                        q[i].st = commit_kill_i ? S_KILL : S_COMM;
                end
            end
            if (do_pop) q.delete(0);
            if (alloc && !(pass && disp_ready_i)) begin
                e.instr = issue_instr_i;
                e.id    = issue_id_i;
                e.rs    = issue_rs_i;
                if (commit_valid_i && commit_id_i == issue_id_i)
                    e.st = commit_kill_i ? S_KILL : S_COMM;
                else
                    e.st = S_WAIT;
                q.push_back(e);
            end
        end
        @(posedge clk_i);
        @(negedge clk_i);
    endtask

    task automatic idle();
        issue_valid_i    = 1'b0;
        accept_i         = 1'b0;
        issue_instr_i    = '0;
        issue_id_i       = '0;
        issue_rs_i       = '0;
        issue_rs_valid_i = '1;
        commit_valid_i   = 1'b0;
        commit_id_i      = '0;
        commit_kill_i    = 1'b0;
        disp_ready_i     = 1'b0;
    endtask

    task automatic drive_issue(input logic [IDW-1:0] id);
        issue_valid_i    = 1'b1;
        accept_i         = 1'b1;
        issue_id_i       = id;
        issue_instr_i    = $urandom;
        issue_rs_i       = {$urandom, $urandom, $urandom};
        issue_rs_valid_i = '1;
    endtask

    // Kill every waiting entry and let the buffer empty, bounded in cycles.
    task automatic drain();
        idle();
        disp_ready_i = 1'b1;
        for (int c = 0; c < 30; c++) begin
            commit_valid_i = 1'b0;
            foreach (q[i]) begin
                if (q[i].st == S_WAIT && !commit_valid_i) begin
                    commit_valid_i = 1'b1;
                    commit_id_i    = q[i].id;
                    commit_kill_i  = 1'b1;
                end
            end
            tick();
            if (q.size() == 0 && count_o == 0) break;
        end
        idle();
        #1;
        checks++;
        if (count_o !== 3'd0) begin
            errors++;
            $display("FAIL drain_timeout count got %0d exp 0", count_o);
        end
    endtask

    task automatic test_reset();
        idle();
        rst_i = 1'b1;
        accept_i = 1'b1;
        tick();
        tick();
        #1;
        checks++; if (count_o !== 3'd0) begin errors++; $display("FAIL reset_count got %0d exp 0", count_o); end
        checks++; if (empty_o !== 1'b1) begin errors++; $display("FAIL reset_empty got %0b exp 1", empty_o); end
        checks++; if (full_o !== 1'b0) begin errors++; $display("FAIL reset_full got %0b exp 0", full_o); end
        checks++; if (disp_valid_o !== 1'b0) begin errors++; $display("FAIL reset_disp_valid got %0b exp 0", disp_valid_o); end
        checks++; if (issue_ready_o !== 1'b1) begin errors++; $display("FAIL reset_ready_all_rs got %0b exp 1", issue_ready_o); end
        issue_rs_valid_i = 3'b011;
        #1;
        checks++; if (issue_ready_o !== 1'b0) begin errors++; $display("FAIL ready_rs_missing got %0b exp 0", issue_ready_o); end
        accept_i = 1'b0;
        #1;
        checks++; if (issue_ready_o !== 1'b1) begin errors++; $display("FAIL ready_not_accepted got %0b exp 1", issue_ready_o); end
        rst_i = 1'b0;
        idle();
        tick();
    endtask

    task automatic test_basic();
        logic [31:0] instr;
        drive_issue(4'd3);
        instr = issue_instr_i;
        #1;
        checks++; if (issue_ready_o !== 1'b1) begin errors++; $display("FAIL basic_ready got %0b exp 1", issue_ready_o); end
        tick();
        idle();
        tick();
        commit_valid_i = 1'b1;
        commit_id_i    = 4'd3;
        #1;
        checks++; if (disp_valid_o !== 1'b0) begin errors++; $display("FAIL basic_no_early_disp got %0b exp 0", disp_valid_o); end
        tick();
        idle();
        #1;
        checks++; if (disp_valid_o !== 1'b1) begin errors++; $display("FAIL basic_disp_valid got %0b exp 1", disp_valid_o); end
        checks++; if (disp_id_o !== 4'd3) begin errors++; $display("FAIL basic_disp_id got %0d exp 3", disp_id_o); end
        checks++; if (count_o !== 3'd1) begin errors++; $display("FAIL basic_count_before got %0d exp 1", count_o); end
        tick();
        #1;
        checks++; if (disp_instr_o !== instr || disp_id_o !== 4'd3) begin
            errors++; $display("FAIL basic_stall_stable got %0h/%0d exp %0h/3", disp_instr_o, disp_id_o, instr);
        end
        disp_ready_i = 1'b1;
        $display("TXN dispatch id=%0d instr=%08h", disp_id_o, disp_instr_o);
        tick();
        idle();
        #1;
        checks++; if (count_o !== 3'd0) begin errors++; $display("FAIL basic_count_after got %0d exp 0", count_o); end
        checks++; if (empty_o !== 1'b1) begin errors++; $display("FAIL basic_empty_after got %0b exp 1", empty_o); end
    endtask

    task automatic test_kill();
        logic [IDW-1:0] got[$];
        for (int i = 1; i <= 3; i++) begin
            drive_issue(IDW'(i));
            tick();
        end
        idle();
        disp_ready_i = 1'b1;
        for (int c = 0; c < 6; c++) begin
            commit_valid_i = (c < 3);
            commit_kill_i  = (c == 0);
            commit_id_i    = IDW'(c + 1);
            #1;
            if (c == 1) begin
                checks++; if (disp_valid_o !== 1'b0) begin errors++; $display("FAIL kill_drop_cycle got %0b exp 0", disp_valid_o); end
            end
            if (disp_valid_o) begin
                got.push_back(disp_id_o);
                $display("TXN dispatch id=%0d instr=%08h", disp_id_o, disp_instr_o);
            end
            tick();
        end
        idle();
        #1;
        checks++; if (got.size() != 2) begin errors++; $display("FAIL kill_disp_count got %0d exp 2", got.size()); end
        if (got.size() == 2) begin
            checks++; if (got[0] !== 4'd2 || got[1] !== 4'd3) begin
                errors++; $display("FAIL kill_order got %0d,%0d exp 2,3", got[0], got[1]);
            end
        end
        checks++; if (count_o !== 3'd0) begin errors++; $display("FAIL kill_count_end got %0d exp 0", count_o); end
    endtask

    task automatic test_full();
        for (int i = 4; i < 8; i++) begin
            drive_issue(IDW'(i));
            tick();
        end
        drive_issue(4'd8);
        #1;
        checks++; if (issue_ready_o !== 1'b0) begin errors++; $display("FAIL full_ready got %0b exp 0", issue_ready_o); end
        checks++; if (full_o !== 1'b1) begin errors++; $display("FAIL full_flag got %0b exp 1", full_o); end
        checks++; if (count_o !== 3'd4) begin errors++; $display("FAIL full_count got %0d exp 4", count_o); end
        tick();
        idle();
        commit_valid_i = 1'b1;
        commit_id_i    = 4'd4;
        tick();
        idle();
        drive_issue(4'd8);
        disp_ready_i = 1'b1;
        #1;
        checks++; if (issue_ready_o !== 1'b0 || disp_valid_o !== 1'b1) begin
            errors++; $display("FAIL full_pop_refuse ready got %0b exp 0 valid got %0b exp 1", issue_ready_o, disp_valid_o);
        end
        tick();
        idle();
        #1;
        checks++; if (count_o !== 3'd3) begin errors++; $display("FAIL full_after_pop got %0d exp 3", count_o); end
        drain();
    endtask

    task automatic test_ignore();
        drive_issue(4'd2);
        tick();
        idle();
        commit_valid_i = 1'b1;
        commit_id_i    = 4'd7;
        tick();
        idle();
        issue_valid_i    = 1'b1;
        issue_id_i       = 4'd9;
        issue_rs_valid_i = '0;
        #1;
        checks++; if (issue_ready_o !== 1'b1) begin errors++; $display("FAIL ignore_ready got %0b exp 1", issue_ready_o); end
        tick();
        idle();
        #1;
        checks++; if (count_o !== 3'd1) begin errors++; $display("FAIL ignore_count got %0d exp 1", count_o); end
        checks++; if (disp_valid_o !== 1'b0) begin errors++; $display("FAIL ignore_disp got %0b exp 0", disp_valid_o); end
        commit_valid_i = 1'b1;
        commit_id_i    = 4'd2;
        tick();
        idle();
        #1;
        checks++; if (disp_valid_o !== 1'b1 || disp_id_o !== 4'd2) begin
            errors++; $display("FAIL ignore_real_commit got %0b/%0d exp 1/2", disp_valid_o, disp_id_o);
        end
        drain();
    endtask

    task automatic test_reset_mid();
        for (int i = 1; i <= 3; i++) begin
            drive_issue(IDW'(i));
            tick();
        end
        idle();
        commit_valid_i = 1'b1;
        commit_id_i    = 4'd1;
        tick();
        idle();
        #1;
        checks++; if (count_o !== 3'd3 || disp_valid_o !== 1'b1) begin
            errors++; $display("FAIL rstmid_pre got %0d/%0b exp 3/1", count_o, disp_valid_o);
        end
        rst_i = 1'b1;
        tick();
        rst_i = 1'b0;
        #1;
        checks++; if (count_o !== 3'd0) begin errors++; $display("FAIL rstmid_count got %0d exp 0", count_o); end
        checks++; if (disp_valid_o !== 1'b0) begin errors++; $display("FAIL rstmid_disp got %0b exp 0", disp_valid_o); end
        checks++; if (empty_o !== 1'b1) begin errors++; $display("FAIL rstmid_empty got %0b exp 1", empty_o); end
        tick();
        #1;
        checks++; if (disp_valid_o !== 1'b0) begin errors++; $display("FAIL rstmid_disp_next got %0b exp 0", disp_valid_o); end
    endtask

    task automatic test_same_cycle_commit();
        logic [31:0] instr;
        drive_issue(4'd5);
        instr          = issue_instr_i;
        commit_valid_i = 1'b1;
        commit_id_i    = 4'd5;
        disp_ready_i   = 1'b1;
        #1;
`ifdef XIF_IBUF_PASSTHRU_EN
        checks++; if (disp_valid_o !== 1'b1 || disp_id_o !== 4'd5 || disp_instr_o !== instr) begin
            errors++; $display("FAIL pass_disp got %0b/%0d/%0h exp 1/5/%0h", disp_valid_o, disp_id_o, disp_instr_o, instr);
        end
        tick();
        idle();
        #1;
        checks++; if (count_o !== 3'd0) begin errors++; $display("FAIL pass_count got %0d exp 0", count_o); end
`else
        checks++; if (disp_valid_o !== 1'b0) begin errors++; $display("FAIL same_cycle_no_bypass got %0b exp 0", disp_valid_o); end
        tick();
        idle();
        #1;
        checks++; if (count_o !== 3'd1 || disp_valid_o !== 1'b1 || disp_id_o !== 4'd5) begin
            errors++; $display("FAIL same_cycle_commit got %0d/%0b/%0d exp 1/1/5", count_o, disp_valid_o, disp_id_o);
        end
        disp_ready_i = 1'b1;
        tick();
        idle();
        #1;
        checks++; if (count_o !== 3'd0) begin errors++; $display("FAIL same_cycle_pop got %0d exp 0", count_o); end
`endif
    endtask

    task automatic test_random();
        logic [IDW-1:0] id;
        bit             ev;
        for (int c = 0; c < 400; c++) begin
            issue_valid_i    = ($urandom_range(0, 99) < 60);
            accept_i         = ($urandom_range(0, 99) < 80);
            issue_rs_valid_i = ($urandom_range(0, 99) < 80) ? 3'b111 : 3'($urandom);
            issue_instr_i    = $urandom;
            issue_rs_i       = {$urandom, $urandom, $urandom};
            id = IDW'($urandom);
            for (int k = 0; k < 64 && id_in_q(id); k++) id = IDW'($urandom);
            issue_id_i     = id;
            commit_valid_i = ($urandom_range(0, 99) < 50);
            commit_kill_i  = ($urandom_range(0, 99) < 30);
            commit_id_i    = IDW'($urandom);
            if ($urandom_range(0, 99) < 25) commit_id_i = issue_id_i;
            else if ($urandom_range(0, 99) < 70) begin
                foreach (q[i]) if (q[i].st == S_WAIT) commit_id_i = q[i].id;
            end
            disp_ready_i = ($urandom_range(0, 99) < 60);
            #1;
            ev = exp_disp_valid();
            checks++; if (count_o !== 3'(q.size())) begin errors++; $display("FAIL rand_count cyc %0d got %0d exp %0d", c, count_o, q.size()); end
            checks++; if (full_o !== (q.size() == DEPTH)) begin errors++; $display("FAIL rand_full cyc %0d got %0b", c, full_o); end
            checks++; if (empty_o !== (q.size() == 0)) begin errors++; $display("FAIL rand_empty cyc %0d got %0b", c, empty_o); end
            checks++; if (issue_ready_o !== exp_ready()) begin errors++; $display("FAIL rand_ready cyc %0d got %0b exp %0b", c, issue_ready_o, exp_ready()); end
            checks++; if (disp_valid_o !== ev) begin errors++; $display("FAIL rand_disp_valid cyc %0d got %0b exp %0b", c, disp_valid_o, ev); end
            if (ev && !exp_pass()) begin
                checks++; if (disp_id_o !== q[0].id || disp_instr_o !== q[0].instr || disp_rs_o !== q[0].rs) begin
                    errors++; $display("FAIL rand_payload cyc %0d got id %0d instr %08h exp id %0d instr %08h", c, disp_id_o, disp_instr_o, q[0].id, q[0].instr);
                end
            end
            if (disp_valid_o && disp_ready_i) $display("TXN dispatch id=%0d instr=%08h", disp_id_o, disp_instr_o);
            tick();
        end
        drain();
    endtask

    initial begin
        idle();
        rst_i = 1'b1;
        test_reset();
        test_basic();
        test_kill();
        test_full();
        test_ignore();
        test_reset_mid();
        test_same_cycle_commit();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
